// File: rtl/unidad_memoria.sv
// Memory/stack datapath for the DAPA2014 multicycle control unit: PC, SP, MAR, MDR
// and word-addressed data memory, driven by per-cycle control strobes.
module unidad_memoria #(
  parameter int unsigned     DW      = 16,
  parameter int unsigned     AW      = 8,
  parameter logic [AW-1:0]   PC_INIT = '0,
  parameter logic [AW-1:0]   SP_INIT = '1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] bus_in,
  output logic [DW-1:0] bus_out,
  output logic          bus_oe,
  input  logic          ipc,
  input  logic          wpc,
  input  logic          rpc,
  input  logic          cpc,
  input  logic          isp,
  input  logic          dsp,
  input  logic          csp,
  input  logic          rsp,
  input  logic          wmar,
  input  logic          wmdr,
  input  logic          i_o,
  input  logic          rmem,
  input  logic          wmem,
  output logic [AW-1:0] pc,
  output logic [AW-1:0] sp,
  output logic [AW-1:0] mar,
  output logic [DW-1:0] mdr,
  output logic          err
);

  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] sp_q, sp_d;
  logic [AW-1:0] mar_q, mar_d;
  logic [DW-1:0] mdr_q, mdr_d;
  logic          err_q, err_d;

  logic [DW-1:0] mem [2**AW];

  logic          drv_mdr;
  logic [DW-1:0] bus;
  logic [DW-1:0] mem_rd;

  assign drv_mdr = i_o & ~wmdr;
  assign mem_rd  = mem[mar_q];

  // Bus driver: MDR has priority over PC, PC over SP; silent while in reset.
  always_comb begin
    bus_out = '0;
    bus_oe  = 1'b0;
    if (!reset) begin
      if (drv_mdr) begin
        bus_out = mdr_q;
        bus_oe  = 1'b1;
      end else if (rpc) begin
        bus_out = DW'(pc_q);
        bus_oe  = 1'b1;
      end else if (rsp) begin
        bus_out = DW'(sp_q);
        bus_oe  = 1'b1;
      end
    end
  end

  assign bus = bus_oe ? bus_out : bus_in;

  always_comb begin
    pc_d = pc_q;
    if (cpc)      pc_d = PC_INIT;
    else if (wpc) pc_d = bus[AW-1:0];
    else if (ipc) pc_d = pc_q + AW'(1);

    sp_d = sp_q;
    if (csp)              sp_d = SP_INIT;
    else if (isp && !dsp) sp_d = sp_q + AW'(1);
    else if (dsp && !isp) sp_d = sp_q - AW'(1);

    mar_d = wmar ? bus[AW-1:0] : mar_q;

    // A memory-side MDR load without rmem is a protocol error; MDR keeps its value.
    mdr_d = mdr_q;
    if (wmdr) begin
      if (i_o) begin
        if (rmem) mdr_d = mem_rd;
      end else begin
        mdr_d = bus;
      end
    end

    err_d = err_q
          | (drv_mdr & rpc) | (drv_mdr & rsp) | (rpc & rsp)
          | (isp & dsp)
          | (wmem & rmem)
          | (wmdr & i_o & ~rmem);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= PC_INIT;
      sp_q  <= SP_INIT;
      mar_q <= '0;
      mdr_q <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      sp_q  <= sp_d;
      mar_q <= mar_d;
      mdr_q <= mdr_d;
      err_q <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && wmem) mem[mar_q] <= mdr_q;
  end

  assign pc  = pc_q;
  assign sp  = sp_q;
  assign mar = mar_q;
  assign mdr = mdr_q;
  assign err = err_q;

endmodule
